// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART frame transmitter (and the matching receiver):
//   - uart_state_e : frame FSM states
//   - PAR_*        : encodings of the PARITY parameter
//   - cnt_width    : bit-period counter width for a given CLKS_PER_BIT
//   - idx_width    : bit-index width for a given DATA_BITS
//   - parity_bit   : parity of a (zero-extended) data word
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Widest payload supported; parity is always computed on a word of this width.
  localparam int MAX_DATA_BITS = 9;

  // Counter must hold 0..clks-1; never narrower than one bit.
  function automatic int cnt_width(input int clks);
    if (clks <= 2) begin
      return 1;
    end else begin
      return $clog2(clks);
    end
  endfunction

  // Bit index must hold 0..bits-1; never narrower than one bit.
  function automatic int idx_width(input int bits);
    if (bits <= 2) begin
      return 1;
    end else begin
      return $clog2(bits);
    end
  endfunction

  // Unused upper bits of data must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    case (mode)
      PAR_ODD:  return ~(^data);
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1 while
// running and wraps at every bit boundary; held at zero while not running so
// the first bit of a frame always gets a full period.
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_run          count enable; low clears the counter (restart)
//   o_bit_end      high on the last cycle of each bit
//   o_bit_pre_end  high on the second-to-last cycle of each bit
// -----------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_bit_end,
  output logic o_bit_pre_end
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Bit-period counter: cleared when idle, wraps to zero at each bit boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r <= '0;
    end else if (!i_run) begin
      cnt_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign o_bit_end     = i_run && (cnt_r == CNT_LAST);
  // Used to register a pulse that then lines up with the last cycle of a bit.
  assign o_bit_pre_end = i_run && (cnt_r == CNT_PRE);

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART transmitter: start bit, DATA_BITS payload (LSB first),
// optional odd/even parity, 1 or 2 stop bits. A one-entry holding buffer lets
// a second word queue up so frames go out back-to-back with no idle bit.
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_tx_dv      data valid; word accepted when i_tx_dv && o_tx_ready
//   i_tx_byte    payload word
//   o_tx_ready   high while the holding buffer is empty
//   o_tx_act     high from start bit through last stop bit
//   o_tx_serial  serial line, idles high
//   o_tx_done    one-cycle pulse on the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tx_dv,
  input  logic [DATA_BITS-1:0] i_tx_byte,
  output logic                 o_tx_ready,
  output logic                 o_tx_act,
  output logic                 o_tx_serial,
  output logic                 o_tx_done
);

  localparam int IDX_W = idx_width(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  uart_state_e state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] buf_r;
  logic                 buf_full_r;
  logic [IDX_W-1:0]     bit_idx_r;
  logic                 par_r;
  logic                 stop_idx_r;
  logic                 serial_r;
  logic                 act_r;
  logic                 done_r;
  logic                 ready_r;

  logic                     accept_s;
  logic                     run_s;
  logic                     bit_end_s;
  logic                     pre_end_s;
  logic                     last_stop_s;
  logic                     frame_end_s;
  logic                     load_s;
  logic                     direct_s;
  logic                     buf_take_s;
  logic                     buf_write_s;
  logic [DATA_BITS-1:0]     load_word_s;
  logic [MAX_DATA_BITS-1:0] word_ext_s;
  logic [IDX_W-1:0]         next_idx_s;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tick (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_run         (run_s),
    .o_bit_end     (bit_end_s),
    .o_bit_pre_end (pre_end_s)
  );

  assign accept_s   = i_tx_dv && ready_r;
  assign run_s      = (state_r != ST_IDLE);
  assign next_idx_s = bit_idx_r + IDX_ONE;

  // Which stop bit is the final one of the frame.
  always_comb begin
    last_stop_s = 1'b0;
    if (STOP_BITS == 1) begin
      last_stop_s = 1'b1;
    end else begin
      last_stop_s = stop_idx_r;
    end
  end

  assign frame_end_s = (state_r == ST_STOP) && bit_end_s && last_stop_s;

  // Pick the word that starts the next frame: buffered word has priority over
  // a fresh one; anything not loaded directly lands in the holding buffer.
  always_comb begin
    load_s      = 1'b0;
    direct_s    = 1'b0;
    buf_take_s  = 1'b0;
    load_word_s = '0;
    if (state_r == ST_IDLE) begin
      if (accept_s) begin
        load_s      = 1'b1;
        direct_s    = 1'b1;
        load_word_s = i_tx_byte;
      end else begin
        load_s = 1'b0;
      end
    end else if (frame_end_s) begin
      if (buf_full_r) begin
        load_s      = 1'b1;
        buf_take_s  = 1'b1;
        load_word_s = buf_r;
      end else if (accept_s) begin
        load_s      = 1'b1;
        direct_s    = 1'b1;
        load_word_s = i_tx_byte;
      end else begin
        load_s = 1'b0;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  assign buf_write_s = accept_s && !direct_s;

  // Zero-extend the loaded word so parity only sees real payload bits.
  always_comb begin
    word_ext_s                  = '0;
    word_ext_s[DATA_BITS-1:0]   = load_word_s;
  end

  // Holding buffer; ready mirrors buffer-empty one cycle after each change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_r      <= '0;
      buf_full_r <= 1'b0;
      ready_r    <= 1'b1;
    end else if (buf_write_s) begin
      buf_r      <= i_tx_byte;
      buf_full_r <= 1'b1;
      ready_r    <= 1'b0;
    end else if (buf_take_s) begin
      buf_full_r <= 1'b0;
      ready_r    <= 1'b1;
    end
  end

  // Frame FSM with registered line, activity and done outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      shift_r    <= '0;
      bit_idx_r  <= '0;
      par_r      <= 1'b0;
      stop_idx_r <= 1'b0;
      serial_r   <= 1'b1;
      act_r      <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      // Set one cycle early so the pulse sits on the last stop-bit cycle.
      done_r <= (state_r == ST_STOP) && pre_end_s && last_stop_s;
      if (load_s) begin
        state_r    <= ST_START;
        shift_r    <= load_word_s;
        par_r      <= parity_bit(word_ext_s, PARITY);
        bit_idx_r  <= '0;
        stop_idx_r <= 1'b0;
        serial_r   <= 1'b0;
        act_r      <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            serial_r <= 1'b1;
            act_r    <= 1'b0;
          end
          ST_START: begin
            if (bit_end_s) begin
              state_r  <= ST_DATA;
              serial_r <= shift_r[0];
            end
          end
          ST_DATA: begin
            if (bit_end_s) begin
              if (bit_idx_r == IDX_LAST) begin
                bit_idx_r <= '0;
                if (PARITY != PAR_NONE) begin
                  state_r  <= ST_PARITY;
                  serial_r <= par_r;
                end else begin
                  state_r  <= ST_STOP;
                  serial_r <= 1'b1;
                end
              end else begin
                bit_idx_r <= next_idx_s;
                serial_r  <= shift_r[next_idx_s];
              end
            end
          end
          ST_PARITY: begin
            if (bit_end_s) begin
              state_r  <= ST_STOP;
              serial_r <= 1'b1;
            end
          end
          ST_STOP: begin
            if (bit_end_s) begin
              if (!last_stop_s) begin
                stop_idx_r <= 1'b1;
              end else begin
                // Nothing queued: frame ends and the line idles.
                state_r    <= ST_IDLE;
                stop_idx_r <= 1'b0;
                act_r      <= 1'b0;
              end
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            serial_r <= 1'b1;
            act_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_tx_serial = serial_r;
  assign o_tx_act    = act_r;
  assign o_tx_done   = done_r;
  assign o_tx_ready  = ready_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame. Five instances with CLKS_PER_BIT=4:
//   0: 8E1   1: 8O1   2: 8N2   3: 8N1   4: 7N1
// Stimulus pushes expected frames into a scoreboard queue; one monitor per
// instance decodes the serial line and pops/compares each frame it sees.
module tb_uart_tx_frame;

  localparam int C  = 4;
  localparam int NI = 5;

  typedef struct packed {
    logic [2:0] id;
    logic [8:0] data;
    logic       par;
  } exp_t;

  function int db_of(input int i);
    case (i)
      4:       return 7;
      default: return 8;
    endcase
  endfunction

  function int par_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 0;
    endcase
  endfunction

  function int sb_of(input int i);
    case (i)
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  logic       i_clk;
  logic       rst_n;
  logic       dv_a   [NI];
  logic [8:0] byte_a [NI];
  wire        ready_a [NI];
  wire        act_a   [NI];
  wire        ser_a   [NI];
  wire        done_a  [NI];

  exp_t exp_q[$];
  int   n_cmp;
  int   n_err;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int g, input logic [8:0] d, input logic p);
    exp_t e;
    e.id   = 3'(g);
    e.data = d;
    e.par  = p;
    exp_q.push_back(e);
  endtask

  // Take n negedge samples of one instance's outputs.
  task automatic sample_n(input int g, input int n, output int ones, output int dns,
                          output int acts, output logic dl, output logic ab);
    ones = 0; dns = 0; acts = 0; dl = 1'b0; ab = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      if (ser_a[g] === 1'b1) ones++;
      if (act_a[g] === 1'b1) acts++;
      dl = (done_a[g] === 1'b1);
      if (dl) dns++;
      if (rst_n !== 1'b1) ab = 1'b1;
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_frame #(
      .CLKS_PER_BIT (C),
      .DATA_BITS    (db_of(g)),
      .PARITY       (par_of(g)),
      .STOP_BITS    (sb_of(g))
    ) u_dut (
      .i_clk       (i_clk),
      .i_rst_n     (rst_n),
      .i_tx_dv     (dv_a[g]),
      .i_tx_byte   (byte_a[g][db_of(g)-1:0]),
      .o_tx_ready  (ready_a[g]),
      .o_tx_act    (act_a[g]),
      .o_tx_serial (ser_a[g]),
      .o_tx_done   (done_a[g])
    );

    initial begin : mon
      int ones, dns, acts, tdn, tact, flen;
      logic dl, ab, abt, stab, stop_ok, p;
      logic [8:0] d;
      exp_t e;
      forever begin
        @(negedge i_clk);
        if (rst_n === 1'b1 && ser_a[g] === 1'b0) begin
          tdn  = (done_a[g] === 1'b1) ? 1 : 0;
          tact = (act_a[g] === 1'b1) ? 1 : 0;
          sample_n(g, C - 1, ones, dns, acts, dl, ab);
          stab = (ones == 0); tdn += dns; tact += acts; abt = ab;
          d = '0;
          for (int b = 0; b < db_of(g); b++) begin
            sample_n(g, C, ones, dns, acts, dl, ab);
            d[b] = (ones == C);
            if (ones != 0 && ones != C) stab = 1'b0;
            tdn += dns; tact += acts; abt |= ab;
          end
          p = 1'b0;
          if (par_of(g) != 0) begin
            sample_n(g, C, ones, dns, acts, dl, ab);
            p = (ones == C);
            if (ones != 0 && ones != C) stab = 1'b0;
            tdn += dns; tact += acts; abt |= ab;
          end
          stop_ok = 1'b1;
          for (int s = 0; s < sb_of(g); s++) begin
            sample_n(g, C, ones, dns, acts, dl, ab);
            if (ones != C) stop_ok = 1'b0;
            tdn += dns; tact += acts; abt |= ab;
          end
          flen = C * (1 + db_of(g) + ((par_of(g) != 0) ? 1 : 0) + sb_of(g));
          if (!abt) begin
            check("frame_expected", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("frame_instance", g, int'(e.id));
              check("frame_data", int'(d), int'(e.data));
              check("frame_parity", int'(p), int'(e.par));
              check("frame_bits_stable", int'(stab), 1);
              check("frame_stop_high", int'(stop_ok), 1);
              check("frame_done_count", tdn, 1);
              check("frame_done_last", int'(dl), 1);
              check("frame_act_cycles", tact, flen);
            end
          end
        end
      end
    end
  end

  // Single frame on an idle instance, with cycle-accurate act/done checks.
  task automatic send_timed(input int g, input logic [8:0] data, input logic par, input int done_at);
    int first_done, act_bad;
    push(g, data, par);
    @(negedge i_clk);
    byte_a[g] = data;
    dv_a[g]   = 1'b1;
    first_done = 0;
    act_bad    = 0;
    for (int k = 1; k <= done_at + 2; k++) begin
      @(negedge i_clk);
      if (k == 1) begin
        dv_a[g] = 1'b0;
        check("start_low_after_accept", int'(ser_a[g]), 0);
        check("ready_stays_high_direct", int'(ready_a[g]), 1);
      end
      if (k == 10) byte_a[g] = 9'h000;
      if (done_a[g] === 1'b1 && first_done == 0) first_done = k;
      if ((act_a[g] === 1'b1) != (k <= done_at)) act_bad++;
    end
    check("done_cycle", first_done, done_at);
    check("act_window_errors", act_bad, 0);
  endtask

  task automatic send_plain(input int g, input logic [8:0] data);
    @(negedge i_clk);
    byte_a[g] = data;
    dv_a[g]   = 1'b1;
    @(negedge i_clk);
    dv_a[g]   = 1'b0;
  endtask

  task automatic wait_drain(input int g);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || act_a[g] !== 1'b0) && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    check("drain_in_time", (n < 400) ? 1 : 0, 1);
    repeat (3) @(negedge i_clk);
  endtask

  initial begin
    int dn_cnt, d1, d2, act_bad, lows;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      dv_a[g]   = 1'b0;
      byte_a[g] = 9'h000;
    end
    repeat (3) @(negedge i_clk);
    rst_n = 1'b1;
    @(negedge i_clk);
    for (int g = 0; g < NI; g++) begin
      check("reset_serial", int'(ser_a[g]), 1);
      check("reset_act", int'(act_a[g]), 0);
      check("reset_done", int'(done_a[g]), 0);
      check("reset_ready", int'(ready_a[g]), 1);
    end

    // 8E1 0xA5: even parity 0, 44-cycle frame.
    send_timed(0, 9'h0A5, 1'b0, 44);
    wait_drain(0);
    // 8O1 0x00: odd parity 1.
    push(1, 9'h000, 1'b1);
    send_plain(1, 9'h000);
    wait_drain(1);
    // 8N2 0xFF: no parity slot, 8 stop cycles, 44-cycle frame.
    send_timed(2, 9'h0FF, 1'b0, 44);
    wait_drain(2);

    // 8N1 back-to-back 0x55 then 0x0F, plus 0x33 while the buffer is full.
    push(3, 9'h055, 1'b0);
    push(3, 9'h00F, 1'b0);
    dn_cnt = 0; d1 = 0; d2 = 0; act_bad = 0;
    @(negedge i_clk);
    for (int k = 0; k <= 84; k++) begin
      if (k > 0) @(negedge i_clk);
      if (k == 3)  check("b2b_ready_before_second", int'(ready_a[3]), 1);
      if (k == 4)  check("b2b_ready_after_second", int'(ready_a[3]), 0);
      if (k == 40) check("b2b_ready_while_buffered", int'(ready_a[3]), 0);
      if (k == 40) check("b2b_first_stop_line", int'(ser_a[3]), 1);
      if (k == 41) check("b2b_ready_after_take", int'(ready_a[3]), 1);
      if (k == 41) check("b2b_second_start_line", int'(ser_a[3]), 0);
      if (k == 81) check("b2b_act_after_both", int'(act_a[3]), 0);
      if (done_a[3] === 1'b1) begin
        dn_cnt++;
        if (dn_cnt == 1) d1 = k;
        else d2 = k;
      end
      if (k >= 1 && k <= 80 && act_a[3] !== 1'b1) act_bad++;
      dv_a[3] = 1'b0;
      if (k == 0) begin byte_a[3] = 9'h055; dv_a[3] = 1'b1; end
      if (k == 3) begin byte_a[3] = 9'h00F; dv_a[3] = 1'b1; end
      if (k == 6) begin byte_a[3] = 9'h033; dv_a[3] = 1'b1; end
    end
    check("b2b_done_count", dn_cnt, 2);
    check("b2b_first_done_cycle", d1, 40);
    check("b2b_second_done_cycle", d2, 80);
    check("b2b_act_gaps", act_bad, 0);
    wait_drain(3);

    // 7N1 0x7F, input changed to 0x00 mid-frame; 36-cycle frame.
    send_timed(4, 9'h07F, 1'b0, 36);
    wait_drain(4);

    // Reset during DATA of 0xA5 with 0x3C buffered: nothing further is sent.
    @(negedge i_clk);
    byte_a[0] = 9'h0A5;
    dv_a[0]   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge i_clk);
      dv_a[0] = 1'b0;
      if (k == 2) begin byte_a[0] = 9'h03C; dv_a[0] = 1'b1; end
      if (k == 4) check("rst_test_buffer_full", int'(ready_a[0]), 0);
    end
    check("rst_test_line_before", int'(ser_a[0]), 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_line_high", int'(ser_a[0]), 1);
    check("rst_async_act_low", int'(act_a[0]), 0);
    @(negedge i_clk);
    @(negedge i_clk);
    rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_release_ready", int'(ready_a[0]), 1);
    lows = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge i_clk);
      if (ser_a[0] !== 1'b1 || act_a[0] !== 1'b0) lows++;
    end
    check("rst_nothing_resent", lows, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised UART transmitter; the next generation of the team's fixed 8N1 serializer.
- Adds configurable data width, optional odd/even parity, 1 or 2 stop bits and a one-entry holding buffer, so frames go out back-to-back with no idle gap.
- Sits between a byte producer (CPU/DMA/FIFO) and the board TX pin.
- Clocked by i_clk, with an asynchronous active-low reset.

Parameters:
- CLKS_PER_BIT, 87: i_clk cycles per bit, computed as Fclk/baud. Legal range 2..65535; the counter width is derived from it.
- DATA_BITS, 8: payload bits per frame. Legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame. Legal values 1 or 2.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset. Asserts asynchronously, releases synchronously (external synchroniser).
- i_tx_dv  in  1  data valid. The word is accepted on a rising edge where i_tx_dv && o_tx_ready.
- i_tx_byte  in  DATA_BITS  payload, sent LSB first.
- o_tx_ready  out  1  high when the holding buffer is empty.
- o_tx_act  out  1  high while a frame is being shifted out (start bit through last stop bit).
- o_tx_serial  out  1  serial line. Idles high.
- o_tx_done  out  1  one-cycle pulse on the final clock of each frame's last stop bit.

Behaviour:
- Reset values: o_tx_serial=1, o_tx_act=0, o_tx_done=0, o_tx_ready=1. FSM=IDLE; counters, bit index and buffer cleared.
- Reset mid-frame aborts immediately. The line returns high asynchronously and any buffered word is discarded.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - Every state except IDLE lasts CLKS_PER_BIT cycles per bit; STOP lasts STOP_BITS*CLKS_PER_BIT cycles.
  - PARITY is skipped when PARITY=0.
  - o_tx_serial is registered: START drives 0, DATA drives shift[bit_idx], PARITY drives the parity bit, STOP drives 1.
- Accept path:
  - Accepted word goes to the holding buffer and o_tx_ready falls the next cycle.
  - If IDLE and the buffer is empty, the word instead loads the shift register directly and the FSM enters START. o_tx_serial goes low on the cycle after the accept edge, and o_tx_ready stays high.
  - Latency from accept edge to start-bit line transition: 1 cycle.
- Parity is computed when the word loads the shift register: even parity = XOR of data bits; odd parity = its inverse.
- End of frame (last cycle of STOP):
  - o_tx_done=1.
  - If the buffer is full, its word loads the shift register, the buffer empties, and START begins the next cycle with no idle bit; o_tx_act stays high.
  - Otherwise, if i_tx_dv is high on that same cycle, that word loads directly (same zero-gap behaviour).
  - Otherwise the FSM goes to IDLE and o_tx_act falls.
- i_tx_dv while o_tx_ready=0 is ignored. No overwrite and no error flag.
- i_tx_byte is sampled only on the accept edge; later changes do not affect an in-flight frame.
- Bit index wraps to 0 after DATA_BITS-1. The clock counter resets to 0 at every bit boundary.
- Frame length in cycles: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum (IDLE/START/DATA/PARITY/STOP).
  - PARITY encodings (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2).
  - Helper function for counter width from CLKS_PER_BIT.
  - The future uart_rx_frame reuses this package.
- Natural sub-module: uart_baud_tick. It holds the bit-period counter, produces a bit_end strobe on the last cycle of each bit, and is restartable by the FSM. The FSM, shifter and buffer stay in uart_tx_frame.

Test Plan:
- 8E1, CLKS_PER_BIT=4, send 0xA5: line is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, parity 0, stop 1. o_tx_done pulses at cycle 44 after the accept edge; o_tx_act is high for cycles 1..44.
- 8O1, send 0x00: parity bit 1. 8N2 (PARITY=0, STOP_BITS=2), send 0xFF: no parity slot, stop is high for 8 cycles, frame is 44 cycles.
- Back-to-back, 8N1, CLKS_PER_BIT=4: send 0x55, then 0x0F 3 cycles later.
  - o_tx_ready falls after the second accept.
  - Second start bit begins the cycle after the first o_tx_done; o_tx_act never drops.
  - o_tx_ready rises the cycle after the second word leaves the buffer.
- Overflow: with the buffer full, pulse i_tx_dv with 0x33. 0x33 is never transmitted; only the two queued frames appear.
- DATA_BITS=7, send 0x7F then change i_tx_byte to 0x00 mid-frame: 7 ones are transmitted, and the bit index wraps to the stop bit after bit 6.
- Reset mid-DATA of 0xA5 with the buffer holding 0x3C: o_tx_serial=1 immediately (asynchronous). After release, o_tx_ready=1, and neither the remainder nor 0x3C is ever sent.
